demux1_2_stream: RTL

//  Routes one producer data stream to one of two consumers, selected per beat by
//  'sel'. Each destination has its own 2-entry FIFO, so a stalled consumer does not

---
 rtl/demux1_2_stream_if.sv | 28 ++
 rtl/demux1_2_stream.sv | 70 +++++++
 2 files changed

// File: rtl/demux1_2_stream_if.sv
// Stream bundle for the 1-to-2 demux: one producer side (in_*) and two consumer sides (a_*, b_*).
// The master modport is the environment (producer and consumers); the slave modport is the demux.
interface demux1_2_stream_if #(
    parameter int WIDTH = 8
);
    // Handshake rule on every channel: a beat moves on a rising clk edge where valid & ready are both 1.
    // valid never depends on ready. ready may depend on the routing select of the offered beat.
    logic [WIDTH:0] in_data;
    logic           in_sel;
    logic           in_valid;
    logic           in_ready;
    logic [WIDTH:0] a_data;
    logic           a_valid;
    logic           a_ready;
    logic [WIDTH:0] b_data;
    logic           b_valid;
    logic           b_ready;

    modport master (
        output in_data, in_sel, in_valid, a_ready, b_ready,
        input  in_ready, a_data, a_valid, b_data, b_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, a_ready, b_ready,
        output in_ready, a_data, a_valid, b_data, b_valid
    );
endinterface

// File: rtl/demux1_2_stream.sv
// Routes one input stream to port a or b per beat. Each port has its own 2-entry FIFO,
// so a stalled consumer never blocks the other one. Per-port wrapping delivered-beat counters.
module demux1_2_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    demux1_2_stream_if.slave  bus,
    output logic [CNT_W-1:0]  a_count,
    output logic [CNT_W-1:0]  b_count
);
    // Index 0 is destination a, index 1 is destination b.
    logic [WIDTH:0]   mem    [2][2];
    logic [WIDTH:0]   last   [2];
    logic [1:0]       cnt    [2];
    logic             wr_ptr [2];
    logic             rd_ptr [2];
    logic [CNT_W-1:0] beats  [2];
    logic [1:0]       full;
    logic [1:0]       empty;
    logic [1:0]       push;
    logic [1:0]       pop;

    assign full  = {cnt[1] == 2'd2, cnt[0] == 2'd2};
    assign empty = {cnt[1] == 2'd0, cnt[0] == 2'd0};

    // A full FIFO refuses input even when it pops in the same cycle: no pass-through path.
    assign bus.in_ready = bus.in_sel ? !full[1] : !full[0];
    assign push[0] = bus.in_valid & !bus.in_sel & !full[0];
    assign push[1] = bus.in_valid &  bus.in_sel & !full[1];
    assign pop[0]  = !empty[0] & bus.a_ready;
    assign pop[1]  = !empty[1] & bus.b_ready;

    // When a FIFO drains, its output keeps showing the last delivered beat.
    assign bus.a_valid = !empty[0];
    assign bus.b_valid = !empty[1];
    assign bus.a_data  = empty[0] ? last[0] : mem[0][rd_ptr[0]];
    assign bus.b_data  = empty[1] ? last[1] : mem[1][rd_ptr[1]];
    assign a_count     = beats[0];
    assign b_count     = beats[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                cnt[i]    <= 2'd0;
                wr_ptr[i] <= 1'b0;
                rd_ptr[i] <= 1'b0;
                last[i]   <= '0;
                beats[i]  <= '0;
                for (int j = 0; j < 2; j++) begin
                    mem[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= bus.in_data;
                    wr_ptr[i]         <= !wr_ptr[i];
                end
                if (pop[i]) begin
                    rd_ptr[i] <= !rd_ptr[i];
                    last[i]   <= mem[i][rd_ptr[i]];
                    beats[i]  <= beats[i] + CNT_W'(1);
                end
                cnt[i] <= cnt[i] + {1'b0, push[i]} - {1'b0, pop[i]};
            end
        end
    end
endmodule
